// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multi-cycle control sequencer and the datapath/memories.
//   Decoded fields : opcode, func3, func7_b5 (from Instruction_Parser)
//   Status / ready : alu_zero, imem_ready, dmem_ready
//   Control out    : imem_req, ir_write, pc_write, pc_src, reg_write, alu_src,
//                    alu_op, mem_read, mem_write, mem_to_reg, illegal
//   Observability  : state, instret (CNT_W bits)
// Modports:
//   master - the controller: drives requests/enables, samples fields/readies
//   slave  - datapath and memory side
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic             func7_b5;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;

  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, func3, func7_b5, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg_write, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, illegal, state, instret
  );

  modport slave (
    output opcode, func3, func7_b5, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg_write, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multi-cycle control sequencer for the RISC-V core datapath. Steps each
// instruction through FETCH, DECODE, EXECUTE, MEM and WB, handshaking with
// instruction/data memories that may stall. Unsupported encodings park the
// controller in TRAP until reset.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - multicycle_controller_if.master (fields, readies, control enables,
//           state and retired-instruction count)
// Build option:
//   MCC_PERF_COUNT_EN - when defined, instret counts retired instructions
//                       (wrapping modulo 2^CNT_W); otherwise instret is 0.
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4
  } class_t;

  state_t state_q, state_d;
  class_t class_q, class_d;
  logic   bne_q, bne_d;     // latched func3[0]: 0 = beq, 1 = bne
  logic   retire;

  logic       imem_req, ir_write, pc_write, pc_src, reg_write, alu_src;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, illegal;

  // func7_b5 only matters to the ALU's own func decode; alu_op=10 hands it off.
  logic unused_func7;
  assign unused_func7 = bus.func7_b5;

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    bne_d      = bne_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;   // pc_src stays 0: PC+4
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
        bne_d   = bus.func3[0];
        unique case (bus.opcode)
          7'b0110011: class_d = C_R;
          7'b0010011: class_d = C_I;
          7'b0000011: class_d = C_LOAD;
          7'b0100011: class_d = C_STORE;
          7'b1100011: begin
            class_d = C_BRANCH;
            // Only beq/bne are supported.
            if (bus.func3[2:1] != 2'b00) state_d = S_TRAP;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_EXECUTE: begin
        unique case (class_q)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_I: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          default: begin   // C_BRANCH
            alu_op   = 2'b01;
            pc_write = bne_q ? !bus.alu_zero : bus.alu_zero;
            pc_src   = pc_write;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        if (class_q == C_STORE) begin
          mem_write = 1'b1;
          if (bus.dmem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          mem_read = 1'b1;
          if (bus.dmem_ready) state_d = S_WB;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == C_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_FETCH;
    endcase

    // Reset silences every output in the same cycle, dropping any request.
    if (reset) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

`ifdef MCC_PERF_COUNT_EN
  logic [CNT_W-1:0] instret_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      bne_q     <= 1'b0;
`ifdef MCC_PERF_COUNT_EN
      instret_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      bne_q     <= bne_d;
`ifdef MCC_PERF_COUNT_EN
      if (retire) instret_q <= instret_q + 1'b1;
`endif
    end
  end

`ifdef MCC_PERF_COUNT_EN
  assign bus.instret = reset ? '0 : instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign bus.instret   = '0;
`endif

  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.illegal    = illegal;
  assign bus.state      = reset ? 3'd0 : state_q;

endmodule
